fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the core.
- Owns the fetch PC and issues one request at a time on the SRAM-like instruction port (req/addr_ok/data_ok).
- Holds the fetched instruction for decode until it is accepted.
- Applies redirects (eret, exception, misprediction) and branch prediction, and discards responses that belong to cancelled fetches.
- Sits between the instruction-side bus bridge and the IF/ID pipeline register, and replaces the free-running PC register.

Parameters:
- RESET_ADDR, 32'hbfc0_0000, fetch address after reset
- EXC_ADDR, 32'hbfc0_0380, exception entry address

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  1: decode cannot accept the held instruction
- bp_take  in  1  prediction for the held instruction: 1 = taken
- bp_target  in  32  predicted target
- pf  in  1  prediction failed
- real_target  in  32  correct target on misprediction
- exc_oc  in  1  exception occurred
- eret  in  1  eret retiring
- epc  in  32  eret return address
- inst_req  out  1  fetch request
- inst_addr  out  32  fetch address
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  read data valid
- inst_rdata  in  32  read data
- if_valid  out  1  held instruction valid
- if_pc  out  32  PC of the held instruction
- if_inst  out  32  held instruction word

Behaviour:
- Reset, sampled at a rising edge with reset=1:
  - state=IDLE, fetch_pc=RESET_ADDR
  - inst_req=0, if_valid=0, if_pc=0, if_inst=0
  - cancel=0, redir_vld=0, redir_pc=0
- Redirect is defined as eret|exc_oc|pf. Target priority: eret→epc, then exc_oc→EXC_ADDR, then pf→real_target.
  - Redirect ignores stall.
  - A redirect always clears if_valid at the next edge.
  - A later redirect overwrites a pending one.
- All outputs are registered except inst_req and inst_addr, which decode state: inst_req=(state==REQ), inst_addr=fetch_pc.
- States IDLE, REQ, WAIT, HOLD; at most one outstanding request.
- IDLE: go to REQ on the next cycle. If a redirect occurs in IDLE, fetch_pc=target.
- REQ: inst_addr stays stable until inst_addr_ok (bus rule).
  - Redirect without addr_ok: set redir_vld=1 and redir_pc=target; stay in REQ with the address unchanged.
  - addr_ok: go to WAIT. Set cancel=1 if redir_vld is set or a redirect occurs in this same cycle; capture redir_pc on a same-cycle redirect.
- WAIT:
  - data_ok with cancel=1: drop the data; fetch_pc=redir_pc; clear cancel and redir_vld; go to REQ.
  - data_ok with cancel=0 and no redirect: if_inst=inst_rdata, if_pc=fetch_pc, if_valid=1; go to HOLD.
  - data_ok with cancel=0 and a same-cycle redirect: drop the data; fetch_pc=target; go to REQ.
  - Redirect without data_ok: set cancel=1, redir_vld=1, redir_pc=target; stay in WAIT.
- HOLD:
  - Redirect: if_valid=0, fetch_pc=target, go to REQ.
  - Else if !stall (handoff): if_valid=0, fetch_pc = bp_take ? bp_target : if_pc+4, go to REQ.
  - Else stay in HOLD with all outputs unchanged.
- Handoff takes effect at the edge where if_valid=1 and stall=0.
- bp_take and bp_target are sampled only at handoff.
- Arithmetic: if_pc+4 is 32-bit modulo; wrap at 0xffff_fffc → 0 is not trapped.
- Bus contract: data_ok never arrives in the same cycle as its own addr_ok; the minimum addr_ok→data_ok spacing is 1 cycle. data_ok outside WAIT is ignored.
- Reset mid-transaction returns to IDLE. Bus draining is the bridge's job; the bridge is reset by the same signal.
- Best-case throughput: 1 instruction per 3 cycles (REQ→WAIT→HOLD) with addr_ok and data_ok at minimum latency.

Decomposition:
- Shared package fetch_pkg: RESET_ADDR/EXC_ADDR constants and the fetch_state_t enum {IDLE, REQ, WAIT, HOLD}.
- One sub-module: fetch_redir_sel, combinational priority mux producing redirect and target from eret/exc_oc/pf.

Test Plan:
- Reset then release, addr_ok=1 on the first REQ, data_ok 2 cycles later with rdata=0x2408_0001, stall=0 → inst_addr=0xbfc0_0000, if_valid=1 with if_pc=0xbfc0_0000, next inst_addr=0xbfc0_0004.
- HOLD with stall=1 for 3 cycles → if_valid, if_pc and if_inst unchanged and inst_req=0. At release with bp_take=1, bp_target=0xbfc0_0100 → next inst_addr=0xbfc0_0100.
- exc_oc=1 while in REQ with addr_ok withheld 2 cycles → inst_addr stays at the old value. After addr_ok, the next data_ok is dropped (if_valid stays 0) and the next request uses 0xbfc0_0380.
- eret=1, exc_oc=1 and pf=1 in the same cycle in HOLD with epc=0x8000_1234 → if_valid=0, next inst_addr=0x8000_1234.
- pf=1 with real_target=0xbfc0_0040 in the same cycle as a non-cancelled data_ok → data discarded, if_valid=0, next inst_addr=0xbfc0_0040.
- Assert reset while in WAIT → next cycle state=IDLE, inst_req=0, if_valid=0. First request after release uses 0xbfc0_0000, and a stale data_ok arriving in IDLE is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch controller: the default reset
// and exception entry addresses and the fetch sequencer state type.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] RESET_ADDR = 32'hbfc0_0000;
    localparam logic [31:0] EXC_ADDR   = 32'hbfc0_0380;

    // IDLE : one cycle after reset before the first request
    // REQ  : request driven on the bus, waiting for addr_ok
    // WAIT : request accepted, waiting for data_ok
    // HOLD : fetched instruction held for decode
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_redir_sel.sv
// ---------------------------------------------------------------------------
// fetch_redir_sel
// Combinational priority select for PC redirects. A redirect is any of
// eret, exc_oc or pf; the target priority is eret (epc), then exception
// (EXC_ADDR), then misprediction (real_target).
//
// Ports:
//   eret, exc_oc, pf  in   redirect sources
//   epc               in   eret return address
//   real_target       in   corrected target on misprediction
//   redirect          out  any redirect this cycle
//   target            out  selected redirect target
// ---------------------------------------------------------------------------
module fetch_redir_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_ADDR = fetch_pkg::EXC_ADDR
) (
    input  logic        eret,
    input  logic        exc_oc,
    input  logic        pf,
    input  logic [31:0] epc,
    input  logic [31:0] real_target,
    output logic        redirect,
    output logic [31:0] target
);

    always_comb begin
        redirect = eret | exc_oc | pf;
        if (eret) begin
            target = epc;
        end else if (exc_oc) begin
            target = EXC_ADDR;
        end else begin
            target = real_target;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch sequencer. Owns the fetch PC, issues one request at a
// time on the SRAM-like instruction port, holds the returned instruction for
// decode until accepted, and applies redirects and branch prediction.
// Responses belonging to fetches cancelled by a redirect are dropped.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   stall               decode cannot accept the held instruction
//   bp_take, bp_target  prediction for the held instruction (used at handoff)
//   pf, real_target     misprediction and its corrected target
//   exc_oc              exception occurred (target EXC_ADDR)
//   eret, epc           eret retiring and its return address
//   inst_req, inst_addr instruction port request (decoded from state)
//   inst_addr_ok        request accepted
//   inst_data_ok        read data valid
//   inst_rdata          read data
//   if_valid, if_pc,    held instruction for decode (registered)
//   if_inst
// ---------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = fetch_pkg::RESET_ADDR,
    parameter logic [31:0] EXC_ADDR   = fetch_pkg::EXC_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        bp_take,
    input  logic [31:0] bp_target,
    input  logic        pf,
    input  logic [31:0] real_target,
    input  logic        exc_oc,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    fetch_state_t state, state_nx;
    logic [31:0]  fetch_pc, fetch_pc_nx;
    logic         if_valid_nx;
    logic [31:0]  if_pc_nx, if_inst_nx;
    // cancel: the accepted request's response must be dropped.
    // redir_vld/redir_pc: a redirect arrived while a request was on the bus
    // and must be applied once that request completes.
    logic         cancel, cancel_nx;
    logic         redir_vld, redir_vld_nx;
    logic [31:0]  redir_pc, redir_pc_nx;

    logic         redirect;
    logic [31:0]  target;

    fetch_redir_sel #(
        .EXC_ADDR (EXC_ADDR)
    ) u_redir_sel (
        .eret        (eret),
        .exc_oc      (exc_oc),
        .pf          (pf),
        .epc         (epc),
        .real_target (real_target),
        .redirect    (redirect),
        .target      (target)
    );

    // The request and its address decode directly from state; the address
    // stays stable in REQ because fetch_pc is only rewritten outside REQ.
    assign inst_req  = (state == REQ);
    assign inst_addr = fetch_pc;

    always_comb begin
        // NOTE: every signal gets a default before the case so that paths
        // which do not assign it hold state instead of inferring a latch.
        state_nx     = state;
        fetch_pc_nx  = fetch_pc;
        if_valid_nx  = if_valid & ~redirect;
        if_pc_nx     = if_pc;
        if_inst_nx   = if_inst;
        cancel_nx    = cancel;
        redir_vld_nx = redir_vld;
        redir_pc_nx  = redir_pc;

        unique case (state)
            IDLE: begin
                state_nx = REQ;
                if (redirect) begin
                    fetch_pc_nx = target;
                end
            end

            REQ: begin
                if (inst_addr_ok) begin
                    state_nx  = WAIT;
                    cancel_nx = redir_vld | redirect;
                    if (redirect) begin
                        redir_vld_nx = 1'b1;
                        redir_pc_nx  = target;
                    end
                end else if (redirect) begin
                    // Address must not change until accepted; park the target.
                    redir_vld_nx = 1'b1;
                    redir_pc_nx  = target;
                end
            end

            WAIT: begin
                if (inst_data_ok) begin
                    state_nx     = REQ;
                    cancel_nx    = 1'b0;
                    redir_vld_nx = 1'b0;
                    if (redirect) begin
                        // A redirect in the same cycle supersedes any parked one.
                        fetch_pc_nx = target;
                    end else if (cancel) begin
                        fetch_pc_nx = redir_pc;
                    end else begin
                        state_nx    = HOLD;
                        if_valid_nx = 1'b1;
                        if_pc_nx    = fetch_pc;
                        if_inst_nx  = inst_rdata;
                    end
                end else if (redirect) begin
                    cancel_nx    = 1'b1;
                    redir_vld_nx = 1'b1;
                    redir_pc_nx  = target;
                end
            end

            HOLD: begin
                if (redirect) begin
                    state_nx    = REQ;
                    if_valid_nx = 1'b0;
                    fetch_pc_nx = target;
                end else if (!stall) begin
                    // Handoff to decode; prediction is sampled only here.
                    state_nx    = REQ;
                    if_valid_nx = 1'b0;
                    fetch_pc_nx = bp_take ? bp_target : if_pc + 32'd4;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_ADDR;
            if_valid  <= 1'b0;
            if_pc     <= 32'd0;
            if_inst   <= 32'd0;
            cancel    <= 1'b0;
            redir_vld <= 1'b0;
            redir_pc  <= 32'd0;
        end else begin
            state     <= state_nx;
            fetch_pc  <= fetch_pc_nx;
            if_valid  <= if_valid_nx;
            if_pc     <= if_pc_nx;
            if_inst   <= if_inst_nx;
            cancel    <= cancel_nx;
            redir_vld <= redir_vld_nx;
            redir_pc  <= redir_pc_nx;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations, then randomized redirects, stalls, predictions and bus
// latencies compared every cycle against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        bp_take;
    logic [31:0] bp_target;
    logic        pf;
    logic [31:0] real_target;
    logic        exc_oc;
    logic        eret;
    logic [31:0] epc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .bp_take      (bp_take),
        .bp_target    (bp_target),
        .pf           (pf),
        .real_target  (real_target),
        .exc_oc       (exc_oc),
        .eret         (eret),
        .epc          (epc),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // ---------------- transaction-level model ----------------
    // The fetcher is described by what it is doing with the bus:
    // starting up, asking for an address, waiting on data, or holding an
    // instruction. A redirect dooms any in-progress fetch and updates the
    // address the next request will use.
    bit          m_starting, m_asking, m_in_flight, m_holding, m_doomed;
    logic [31:0] m_req_addr, m_next_pc, m_hold_pc, m_hold_inst;

    task automatic m_issue(input logic [31:0] a);
        m_asking   = 1'b1;
        m_req_addr = a;
    endtask

    // Applies the inputs the DUT sampled at the edge just passed.
    task automatic model_update();
        logic        r;
        logic [31:0] t;
        r = eret | exc_oc | pf;
        t = eret ? epc : (exc_oc ? EXC_ADDR : real_target);
        if (reset) begin
            m_starting = 1'b1; m_asking = 1'b0; m_in_flight = 1'b0;
            m_holding = 1'b0; m_doomed = 1'b0;
            m_next_pc = RESET_ADDR; m_req_addr = RESET_ADDR;
            m_hold_pc = 32'd0; m_hold_inst = 32'd0;
        end else if (m_starting) begin
            m_starting = 1'b0;
            if (r) m_next_pc = t;
            m_issue(m_next_pc);
        end else if (m_asking) begin
            if (r) begin m_doomed = 1'b1; m_next_pc = t; end
            if (inst_addr_ok) begin m_asking = 1'b0; m_in_flight = 1'b1; end
        end else if (m_in_flight) begin
            if (inst_data_ok) begin
                m_in_flight = 1'b0;
                if (r) m_next_pc = t;
                if (m_doomed || r) begin
                    m_doomed = 1'b0;
                    m_issue(m_next_pc);
                end else begin
                    m_holding   = 1'b1;
                    m_hold_pc   = m_req_addr;
                    m_hold_inst = inst_rdata;
                end
            end else if (r) begin
                m_doomed  = 1'b1;
                m_next_pc = t;
            end
        end else if (m_holding) begin
            if (r) begin
                m_holding = 1'b0;
                m_issue(t);
            end else if (!stall) begin
                m_holding = 1'b0;
                m_issue(bp_take ? bp_target : m_hold_pc + 32'd4);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One compare process: outputs vs model, every cycle, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (inst_req !== m_asking) begin
                n_fail++;
                $display("FAIL inst_req: got %b expected %b (t=%0t)", inst_req, m_asking, $time);
            end
            if (m_asking && inst_addr !== m_req_addr) begin
                n_fail++;
                $display("FAIL inst_addr: got %h expected %h (t=%0t)", inst_addr, m_req_addr, $time);
            end
            if (if_valid !== m_holding) begin
                n_fail++;
                $display("FAIL if_valid: got %b expected %b (t=%0t)", if_valid, m_holding, $time);
            end
            if (if_pc !== m_hold_pc) begin
                n_fail++;
                $display("FAIL if_pc: got %h expected %h (t=%0t)", if_pc, m_hold_pc, $time);
            end
            if (if_inst !== m_hold_inst) begin
                n_fail++;
                $display("FAIL if_inst: got %h expected %h (t=%0t)", if_inst, m_hold_inst, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        chk_en = 1'b1;
    endtask

    // Request in REQ accepted now, data one cycle later (minimum latency).
    task automatic fetch_one(input logic [31:0] d);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = d;
        step();
        inst_data_ok = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 7) == 0) a = 32'hffff_fffc;
        return {a[31:2], 2'b00};
    endfunction

    bit bus_pending;
    int bus_wait;

    initial begin
        reset = 1'b1; stall = 1'b0; bp_take = 1'b0; bp_target = 32'd0;
        pf = 1'b0; real_target = 32'd0; exc_oc = 1'b0; eret = 1'b0; epc = 32'd0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;

        // Reset state
        step(); step();
        check("rst_inst_req", {31'd0, inst_req}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);

        // First fetch, data_ok two cycles after addr_ok, immediate handoff
        reset = 1'b0;
        step();
        check("first_req", {31'd0, inst_req}, 32'd1);
        check("first_addr", inst_addr, 32'hbfc0_0000);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        step();
        inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
        step();
        inst_data_ok = 1'b0;
        check("first_valid", {31'd0, if_valid}, 32'd1);
        check("first_pc", if_pc, 32'hbfc0_0000);
        check("first_inst", if_inst, 32'h2408_0001);
        step();
        check("seq_addr", inst_addr, 32'hbfc0_0004);

        // Stalled hold, then predicted-taken handoff
        stall = 1'b1;
        fetch_one(32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_pc", if_pc, 32'hbfc0_0004);
            check("stall_inst", if_inst, 32'h1234_5678);
            check("stall_req", {31'd0, inst_req}, 32'd0);
        end
        stall = 1'b0; bp_take = 1'b1; bp_target = 32'hbfc0_0100;
        step();
        bp_take = 1'b0;
        check("bp_addr", inst_addr, 32'hbfc0_0100);

        // Exception while the request is not yet accepted
        exc_oc = 1'b1;
        step();
        exc_oc = 1'b0;
        step();
        check("exc_req_hold", {31'd0, inst_req}, 32'd1);
        check("exc_addr_stable", inst_addr, 32'hbfc0_0100);
        fetch_one(32'hdead_beef);
        check("exc_drop_valid", {31'd0, if_valid}, 32'd0);
        check("exc_next_addr", inst_addr, 32'hbfc0_0380);

        // All redirect sources at once in HOLD: eret wins
        stall = 1'b1;
        fetch_one(32'h0000_0001);
        check("hold_valid", {31'd0, if_valid}, 32'd1);
        eret = 1'b1; exc_oc = 1'b1; pf = 1'b1;
        epc = 32'h8000_1234; real_target = 32'hbfc0_0040;
        step();
        eret = 1'b0; exc_oc = 1'b0; pf = 1'b0;
        stall = 1'b0;
        check("prio_valid", {31'd0, if_valid}, 32'd0);
        check("prio_addr", inst_addr, 32'h8000_1234);

        // Misprediction together with a live data_ok
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'h0bad_0bad;
        pf = 1'b1; real_target = 32'hbfc0_0040;
        step();
        inst_data_ok = 1'b0; pf = 1'b0;
        check("pf_drop_valid", {31'd0, if_valid}, 32'd0);
        check("pf_addr", inst_addr, 32'hbfc0_0040);

        // Reset in WAIT, stale data_ok while starting up
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        reset = 1'b1;
        step();
        check("wait_rst_req", {31'd0, inst_req}, 32'd0);
        check("wait_rst_valid", {31'd0, if_valid}, 32'd0);
        reset = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h5555_aaaa;
        step();
        inst_data_ok = 1'b0;
        check("post_rst_req", {31'd0, inst_req}, 32'd1);
        check("post_rst_addr", inst_addr, 32'hbfc0_0000);
        check("post_rst_valid", {31'd0, if_valid}, 32'd0);

        // Randomized phase
        bus_pending = 1'b0;
        bus_wait    = 0;
        for (int c = 0; c < 4000; c++) begin
            int r;
            step();
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            inst_rdata   = $urandom;
            reset        = ($urandom_range(0, 199) == 0);
            stall        = $urandom_range(0, 1) == 1;
            bp_take      = $urandom_range(0, 1) == 1;
            bp_target    = rnd_addr();
            real_target  = rnd_addr();
            epc          = rnd_addr();
            r            = $urandom_range(0, 13);
            eret         = (r == 0) || (r == 4);
            exc_oc       = (r == 1) || (r == 4);
            pf           = (r == 2) || (r == 3) || (r == 4);
            if (reset) begin
                bus_pending = 1'b0;
            end else if (bus_pending) begin
                if (bus_wait > 0) begin
                    bus_wait--;
                end else if ($urandom_range(0, 1) == 1) begin
                    inst_data_ok = 1'b1;
                    bus_pending  = 1'b0;
                end
            end else if (inst_req && $urandom_range(0, 1) == 1) begin
                inst_addr_ok = 1'b1;
                bus_pending  = 1'b1;
                bus_wait     = $urandom_range(0, 2);
            end
        end
        step();
        chk_en = 1'b0;
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
